// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the camera frame capture block
package cam_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } cap_state_t;

  localparam int H_SRC_DEF = 320;
  localparam int V_SRC_DEF = 240;
  localparam int DEPTH_DEF = 19200;
  localparam int ADDR_W    = 15;
  localparam int PIX_W     = 16;
  localparam int COL_W     = 9;
  localparam int ROW_W     = 8;
  localparam int BYTE_W    = 8;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchronizer with rise/fall detection on the synchronized level
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_prev;
  assign o_fall = ~r_s2 & r_prev;

endmodule

// File: rtl/cam_frame_capture.sv
// rtl/cam_frame_capture.sv - captures one camera frame, pairs bytes into RGB565 pixels,
// decimates 2x in both axes and writes kept pixels sequentially into the frame memory.
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int H_SRC = H_SRC_DEF,
  parameter int V_SRC = V_SRC_DEF,
  parameter int DEPTH = (H_SRC / 2) * (V_SRC / 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [BYTE_W-1:0] cam_d,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [PIX_W-1:0]  dia
);

  localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(DEPTH);

  logic w_pclk_q, w_pclk_rise, w_pclk_fall;
  logic w_vsync_q, w_vsync_rise, w_vsync_fall;
  logic w_href_q, w_href_rise, w_href_fall;
  logic w_unused_edges;

  sync_edge u_sync_pclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (cam_pclk),
    .o_q    (w_pclk_q),
    .o_rise (w_pclk_rise),
    .o_fall (w_pclk_fall)
  );

  sync_edge u_sync_vsync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (cam_vsync),
    .o_q    (w_vsync_q),
    .o_rise (w_vsync_rise),
    .o_fall (w_vsync_fall)
  );

  sync_edge u_sync_href (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (cam_href),
    .o_q    (w_href_q),
    .o_rise (w_href_rise),
    .o_fall (w_href_fall)
  );

  assign w_unused_edges = &{w_pclk_q, w_pclk_fall, w_vsync_q, w_href_rise};

  cap_state_t            r_state;
  cap_state_t            w_state_next;
  logic                  r_run;
  logic [BYTE_W-1:0]     r_d1;
  logic [BYTE_W-1:0]     r_d2;
  logic                  r_byte_ph;
  logic [BYTE_W-1:0]     r_hi;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_overflow;
  logic                  r_wea;
  logic [ADDR_W-1:0]     r_addra;
  logic [PIX_W-1:0]      r_dia;
  logic                  w_start_ok;
  logic                  w_byte_stb;
  logic                  w_pix_done;
  logic                  w_keep;

  // r_run blocks a start that arrives on the very first edge after reset release
  assign w_start_ok = start & r_run;
  assign w_byte_stb = (r_state == S_CAPTURE) & w_pclk_rise & w_href_q & ~w_href_fall;
  assign w_pix_done = w_byte_stb & r_byte_ph;
  assign w_keep     = w_pix_done & ~r_col[0] & ~r_row[0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok)   w_state_next = S_ARM;
      S_ARM:     if (w_vsync_fall) w_state_next = S_CAPTURE;
      S_CAPTURE: if (w_vsync_rise) w_state_next = S_DONE;
      S_DONE:                      w_state_next = S_IDLE;
      default:                     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_d1    <= '0;
      r_d2    <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= 1'b1;
      r_d1    <= cam_d;
      r_d2    <= r_d1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_ph  <= 1'b0;
      r_hi       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
      r_wea      <= 1'b0;
      r_addra    <= '0;
      r_dia      <= '0;
    end else begin
      r_wea <= 1'b0;
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_byte_ph  <= 1'b0;
        r_col      <= '0;
        r_row      <= '0;
        r_addr     <= '0;
        r_overflow <= 1'b0;
      end else if (r_state == S_CAPTURE) begin
        if (w_href_fall) begin
          r_byte_ph <= 1'b0;
          r_col     <= '0;
          if (r_row != '1) r_row <= r_row + 1'b1;
        end else if (w_byte_stb) begin
          if (!r_byte_ph) begin
            r_hi      <= r_d2;
            r_byte_ph <= 1'b1;
          end else begin
            r_byte_ph <= 1'b0;
            if (r_col != '1) r_col <= r_col + 1'b1;
          end
        end
        // once the memory is full, further kept pixels only flag overflow
        if (w_keep) begin
          if (r_addr < L_DEPTH) begin
            r_wea   <= 1'b1;
            r_addra <= r_addr;
            r_dia   <= {r_hi, r_d2};
            r_addr  <= r_addr + 1'b1;
          end else begin
            r_overflow <= 1'b1;
          end
        end
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign overflow   = r_overflow;
  assign wea        = r_wea;
  assign ena        = r_wea;
  assign addra      = r_addra;
  assign dia        = r_dia;

endmodule

// File: tb/tb_cam_frame_capture.sv
// tb/tb_cam_frame_capture.sv - directed scoreboard bench for cam_frame_capture on a reduced frame size
module tb_cam_frame_capture;

  localparam int H = 16;
  localparam int V = 8;
  localparam int D = (H / 2) * (V / 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_d = 8'h00;
  logic        busy, frame_done, overflow, ena, wea;
  logic [14:0] addra;
  logic [15:0] dia;

  always #5 clk = ~clk;

  cam_frame_capture #(.H_SRC(H), .V_SRC(V), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_d      (cam_d),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow),
    .ena        (ena),
    .wea        (wea),
    .addra      (addra),
    .dia        (dia)
  );

  typedef struct packed {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t        sb[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_wr = 0;
  int         n_done = 0;
  int         max_addr = 0;
  int         exp_addr = 0;
  logic       ovf_at_done = 1'b0;
  logic [15:0] mem [0:D-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (wea === 1'b1) begin
      n_wr++;
      if (int'(addra) > max_addr) max_addr = int'(addra);
      if (int'(addra) < D) mem[addra] = dia;
      chk("ena_with_wea", {31'd0, ena}, 32'd1);
      chk("write_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("addra", {17'd0, addra}, {17'd0, e.a});
        chk("dia", {16'd0, dia}, {16'd0, e.d});
      end
    end
    if (frame_done === 1'b1) begin
      n_done++;
      ovf_at_done = overflow;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int hp);
    cam_d = b;
    cam_pclk = 1'b0;
    repeat (hp) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (hp) @(negedge clk);
  endtask

  // cap: the DUT is expected to be capturing, so kept pixels go to the scoreboard
  task automatic drive_frame(input int lines, input int hp, input bit cap, input bit rnd,
                             input int start_line, input int abort_line);
    cam_vsync = 1'b1;
    cam_href = 1'b0;
    cam_pclk = 1'b0;
    repeat (8) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (8) @(negedge clk);
    for (int r = 0; r < lines; r++) begin
      if (r == start_line) do_start();
      if (r == abort_line) return;
      cam_href = 1'b1;
      for (int c = 0; c < H; c++) begin
        logic [7:0] hb;
        logic [7:0] lb;
        hb = rnd ? 8'($urandom) : r[7:0];
        lb = rnd ? 8'($urandom) : c[7:0];
        if (cap && (r % 2 == 0) && (c % 2 == 0) && (exp_addr < D)) begin
          sb.push_back({exp_addr[14:0], hb, lb});
          exp_addr++;
        end
        drive_byte(hb, hp);
        drive_byte(lb, hp);
      end
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      repeat (8) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    cam_vsync = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_ena", {31'd0, ena}, 32'd0);
    chk("rst_wea", {31'd0, wea}, 32'd0);
    chk("rst_addra", {17'd0, addra}, 32'd0);
    chk("rst_dia", {16'd0, dia}, 32'd0);

    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_at_release_ignored", {31'd0, busy}, 32'd0);

    // full frame
    do_start();
    @(negedge clk);
    chk("t1_busy_armed", {31'd0, busy}, 32'd1);
    n_wr = 0; n_done = 0; max_addr = 0;
    drive_frame(V, 3, 1'b1, 1'b0, -1, -1);
    chk("t1_writes", n_wr, D);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_max_addr", max_addr, D - 1);
    chk("t1_word9", {16'd0, mem[9]}, 32'h0202);
    chk("t1_done_once", n_done, 1);
    chk("t1_no_overflow", {31'd0, ovf_at_done}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // start mid-frame: that frame is skipped, the next one captured
    n_wr = 0; n_done = 0;
    drive_frame(V, 3, 1'b0, 1'b0, 3, -1);
    chk("t2_no_writes", n_wr, 0);
    chk("t2_no_done", n_done, 0);
    chk("t2_still_armed", {31'd0, busy}, 32'd1);
    drive_frame(V, 3, 1'b1, 1'b0, -1, -1);
    chk("t2_writes", n_wr, D);
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_done_once", n_done, 1);

    // oversize frame
    do_start();
    n_wr = 0; n_done = 0; max_addr = 0;
    drive_frame(V + 2, 3, 1'b1, 1'b0, -1, -1);
    chk("t3_writes", n_wr, D);
    chk("t3_max_addr", max_addr, D - 1);
    chk("t3_overflow_at_done", {31'd0, ovf_at_done}, 32'd1);
    chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
    do_start();
    @(negedge clk);
    chk("t3_overflow_cleared", {31'd0, overflow}, 32'd0);

    // short frame
    n_wr = 0; n_done = 0;
    drive_frame(4, 3, 1'b1, 1'b0, -1, -1);
    chk("t4_writes", n_wr, 2 * (H / 2));
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_done", n_done, 1);
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // pclk at clk/4 with random byte pairs
    do_start();
    n_wr = 0; n_done = 0;
    drive_frame(V, 2, 1'b1, 1'b1, -1, -1);
    chk("t5_writes", n_wr, D);
    chk("t5_sb_empty", sb.size(), 0);
    chk("t5_done", n_done, 1);

    // reset mid-capture
    do_start();
    n_wr = 0; n_done = 0;
    drive_frame(V, 2, 1'b1, 1'b0, -1, 4);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("t6_writes_before_reset", n_wr, 2 * (H / 2));
    chk("t6_busy_before_reset", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("t6_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("t6_rst_ena", {31'd0, ena}, 32'd0);
    chk("t6_rst_wea", {31'd0, wea}, 32'd0);
    chk("t6_rst_addra", {17'd0, addra}, 32'd0);
    chk("t6_rst_dia", {16'd0, dia}, 32'd0);
    cam_href = 1'b1;
    for (int i = 0; i < 8; i++) drive_byte(8'(i), 2);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle_after_release", {31'd0, busy}, 32'd0);
    cam_href = 1'b1;
    for (int i = 0; i < 8; i++) drive_byte(8'(i), 2);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_no_writes_after_reset", n_wr, 2 * (H / 2));
    chk("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
